// File: rtl/gups_mem_bridge.sv
// gups read-modify-write handshake to valid/ready memory command + response channel; GUPS_BRIDGE_TIMEOUT_EN adds a response watchdog.
// Latency: cmd valid 2 cycles after req, gups_ready 1 cycle after rsp; cmd held stable while mem_cmd_ready=0, one outstanding.
module gups_mem_bridge #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gups_req,
  input  logic              gups_write,
  input  logic [ADDR_W-1:0] gups_addr,
  input  logic [DATA_W-1:0] gups_dout,
  output logic              gups_ready,
  output logic [DATA_W-1:0] gups_data_in,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [DATA_W-1:0] mem_cmd_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic [CNT_W-1:0]  update_count,
  output logic [2:0]        err_flags
);

  typedef enum logic [2:0] {
    IDLE, RD_CMD, RD_WAIT, WR_HOLD, WR_CMD, WR_WAIT, RELEASE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;
  logic              aborted;
  logic [1:0]        err_q;
  logic              err_to;
  logic              in_wait;
  logic              timeout;

  assign in_wait   = (state == RD_WAIT) || (state == WR_WAIT);
  assign err_flags = {err_to, err_q};

`ifdef GUPS_BRIDGE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  // Fires on the TIMEOUT_CYC-th cycle spent waiting; a real response always wins.
  assign timeout = in_wait && !mem_rsp_valid && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt <= '0;
      err_to <= 1'b0;
    end else begin
      if (timeout)
        err_to <= 1'b1;
      if (in_wait && !mem_rsp_valid && !timeout)
        wd_cnt <= wd_cnt + 1'b1;
      else
        wd_cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_to  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      addr_q        <= '0;
      dout_q        <= '0;
      aborted       <= 1'b0;
      err_q         <= '0;
      gups_ready    <= 1'b0;
      gups_data_in  <= '0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_we    <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_cmd_wdata <= '0;
      update_count  <= '0;
    end else begin
      gups_ready <= 1'b0;
      if (mem_rsp_valid && !in_wait)
        err_q[0] <= 1'b1;
      // Any dip of req after the read is latched abandons the update.
      if (!gups_req)
        aborted <= 1'b1;

      case (state)
        IDLE: begin
          if (gups_req && !gups_write) begin
            addr_q  <= gups_addr;
            aborted <= 1'b0;
            state   <= RD_CMD;
          end
        end
        RD_CMD: begin
          if (!mem_cmd_valid) begin
            if (!gups_req) begin
              state <= IDLE;
            end else begin
              mem_cmd_valid <= 1'b1;
              mem_cmd_we    <= 1'b0;
              mem_cmd_addr  <= addr_q;
            end
          end else if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            state         <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_rsp_valid || timeout) begin
            if (aborted || !gups_req) begin
              state <= IDLE;
            end else begin
              gups_data_in <= mem_rsp_valid ? mem_rsp_data : '0;
              gups_ready   <= 1'b1;
              state        <= WR_HOLD;
            end
          end
        end
        WR_HOLD: begin
          if (!gups_req) begin
            state <= IDLE;
          end else if (gups_write) begin
            dout_q <= gups_dout;
            if (gups_addr != addr_q)
              err_q[1] <= 1'b1;
            state <= WR_CMD;
          end
        end
        WR_CMD: begin
          if (!mem_cmd_valid) begin
            if (!gups_req) begin
              state <= IDLE;
            end else begin
              mem_cmd_valid <= 1'b1;
              mem_cmd_we    <= 1'b1;
              mem_cmd_addr  <= addr_q;
              mem_cmd_wdata <= dout_q;
            end
          end else if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            state         <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (mem_rsp_valid || timeout) begin
            if (aborted || !gups_req) begin
              state <= IDLE;
            end else begin
              gups_ready <= 1'b1;
              if (mem_rsp_valid)
                update_count <= update_count + 1'b1;
              state <= RELEASE;
            end
          end
        end
        RELEASE: begin
          if (!gups_req)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gups_mem_bridge.sv
// Bench for gups_mem_bridge: bench plays both gups and a memory with configurable delay/stalls.
`timescale 1ns/1ps
module tb_gups_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        gups_req, gups_write;
  logic [63:0] gups_addr, gups_dout;
  logic        gups_ready;
  logic [63:0] gups_data_in;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
  logic [63:0] mem_cmd_addr, mem_cmd_wdata;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic [31:0] update_count;
  logic [2:0]  err_flags;

  always #5 clk = ~clk;

  gups_mem_bridge #(.ADDR_W(64), .DATA_W(64), .CNT_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset),
    .gups_req(gups_req), .gups_write(gups_write), .gups_addr(gups_addr), .gups_dout(gups_dout),
    .gups_ready(gups_ready), .gups_data_in(gups_data_in),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .update_count(update_count), .err_flags(err_flags)
  );

  typedef struct { logic we; logic [63:0] addr; logic [63:0] wdata; } cmd_t;
  typedef struct {
    logic [63:0] addr, wr_addr;
    int          delay, stall;
    logic [63:0] exp_rd, exp_wd;
    logic [2:0]  exp_err;
  } vec_t;

  int n_pass = 0, n_total = 0;
  int ref_cnt = 0;
  logic [63:0] ref_mem [logic [63:0]];

  // memory model state
  logic [63:0] mem_arr [logic [63:0]];
  cmd_t        log_q [$];
  bit          rnd_rdy = 0, mute = 0, inject_rsp = 0, pend = 0, stalled = 0;
  logic [63:0] inject_data = '0, pend_data = '0, prev_addr = '0;
  logic        prev_we = 1'b0;
  int          rsp_delay = 0, stall_req = 0, pend_cnt = 0;

  int ready_pulses = 0;
  bit prev_rdy = 0, expect_to = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Memory: drives ready/rsp on negedge, logs every accepted command.
  initial begin
    mem_cmd_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (inject_rsp) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = inject_data;
        inject_rsp    = 0;
      end else if (pend) begin
        if (pend_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = pend_data;
          pend          = 0;
        end else begin
          pend_cnt--;
        end
      end
      if (stalled) begin
        chk("stall_valid", mem_cmd_valid, 1);
        chk("stall_addr", mem_cmd_addr, prev_addr);
        chk("stall_we", mem_cmd_we, prev_we);
      end
      if (mem_cmd_valid && stall_req > 0) begin
        mem_cmd_ready = 1'b0;
        stall_req--;
      end else if (rnd_rdy) begin
        mem_cmd_ready = 1'($urandom_range(0, 1));
      end else begin
        mem_cmd_ready = 1'b1;
      end
      stalled   = mem_cmd_valid && !mem_cmd_ready;
      prev_addr = mem_cmd_addr;
      prev_we   = mem_cmd_we;
      if (mem_cmd_valid && mem_cmd_ready) begin
        log_q.push_back('{mem_cmd_we, mem_cmd_addr, mem_cmd_wdata});
        if (!mute) begin
          pend     = 1;
          pend_cnt = rsp_delay;
          if (mem_cmd_we) begin
            pend_data = '0;
            mem_arr[mem_cmd_addr] = mem_cmd_wdata;
          end else begin
            pend_data = mem_arr.exists(mem_cmd_addr) ? mem_arr[mem_cmd_addr] : '0;
          end
        end
      end
    end
  end

  // gups_ready must be a lone pulse, caused by a response sampled on the same edge.
  always @(posedge clk) begin
    #1;
    if (gups_ready) begin
      ready_pulses++;
      chk("ready_single", prev_rdy, 0);
      if (!expect_to) chk("ready_after_rsp", mem_rsp_valid, 1);
    end
    prev_rdy = gups_ready;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; gups_req = 1'b0; gups_write = 1'b0; gups_addr = '0; gups_dout = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    pend = 0; stalled = 0; stall_req = 0; inject_rsp = 0;
    log_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ref_cnt = 0;
  endtask

  task automatic wait_ready(input string nm, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!gups_ready && cyc < budget);
    n_total++;
    if (gups_ready) n_pass++;
    else $display("FAIL %s: no gups_ready within %0d cycles", nm, budget);
  endtask

  task automatic do_update(input string nm, input logic [63:0] a, input logic [63:0] wa,
                           input logic [63:0] exp_rd, input logic [63:0] exp_wd,
                           input logic [2:0] exp_err, input bit lat);
    int   cyc;
    cmd_t c;
    gups_req = 1'b1; gups_write = 1'b0; gups_addr = a; gups_dout = '0;
    if (lat) begin
      @(negedge clk); chk({nm, "_valid_t1"}, mem_cmd_valid, 0);
      @(negedge clk); chk({nm, "_valid_t2"}, mem_cmd_valid, 1);
    end
    wait_ready({nm, "_rd_rdy"}, 100, cyc);
    chk({nm, "_rd_data"}, gups_data_in, exp_rd);
    chk({nm, "_rd_ncmd"}, log_q.size(), 1);
    if (log_q.size() > 0) begin
      c = log_q.pop_front();
      chk({nm, "_rd_we"}, c.we, 0);
      chk({nm, "_rd_addr"}, c.addr, a);
    end
    log_q.delete();
    gups_write = 1'b1; gups_addr = wa; gups_dout = gups_data_in + 64'd1;
    wait_ready({nm, "_wr_rdy"}, 100, cyc);
    ref_cnt++;
    chk({nm, "_wr_ncmd"}, log_q.size(), 1);
    if (log_q.size() > 0) begin
      c = log_q.pop_front();
      chk({nm, "_wr_we"}, c.we, 1);
      chk({nm, "_wr_addr"}, c.addr, a);
      chk({nm, "_wr_data"}, c.wdata, exp_wd);
    end
    log_q.delete();
    chk({nm, "_count"}, update_count, 64'(ref_cnt));
    chk({nm, "_err"}, err_flags, exp_err);
    gups_req = 1'b0; gups_write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vec_t        vecs [5];
    int          p, cyc;
    logic [63:0] a, e;
    logic [2:0]  exp_err;

    reset = 1'b0; gups_req = 1'b0; gups_write = 1'b0; gups_addr = '0; gups_dout = '0;
    do_reset();
    chk("rst_ready", gups_ready, 0);
    chk("rst_data_in", gups_data_in, 0);
    chk("rst_cmd_valid", mem_cmd_valid, 0);
    chk("rst_cmd_we", mem_cmd_we, 0);
    chk("rst_cmd_addr", mem_cmd_addr, 0);
    chk("rst_cmd_wdata", mem_cmd_wdata, 0);
    chk("rst_count", update_count, 0);
    chk("rst_err", err_flags, 0);

    mem_arr[64'h40] = 64'h5;
    mem_arr[64'h80] = 64'h1234;
    mem_arr[64'h88] = 64'hFFFF_FFFF_FFFF_FFFF;
    mem_arr[64'h90] = 64'hA5A5_A5A5_A5A5_A5A5;

    rsp_delay = 2;
    do_update("single", 64'h40, 64'h40, 64'h5, 64'h6, 3'b000, 1);

    vecs[0] = '{64'h80, 64'h80, 0, 0, 64'h1234, 64'h1235, 3'b000};
    vecs[1] = '{64'h88, 64'h88, 4, 5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'b000};
    vecs[2] = '{64'h80, 64'h80, 1, 2, 64'h1235, 64'h1236, 3'b000};
    vecs[3] = '{64'h40, 64'h48, 1, 0, 64'h6, 64'h7, 3'b010};
    vecs[4] = '{64'h90, 64'h90, 3, 1, 64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A6, 3'b010};
    for (int i = 0; i < 5; i++) begin
      rsp_delay = vecs[i].delay;
      stall_req = vecs[i].stall;
      do_update($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr_addr,
                vecs[i].exp_rd, vecs[i].exp_wd, vecs[i].exp_err, 0);
    end

    // Spurious response in IDLE, then a read abandoned while its response is pending.
    do_reset();
    p = ready_pulses;
    inject_data = 64'hDEAD;
    inject_rsp  = 1;
    repeat (3) @(negedge clk);
    chk("spur_no_ready", 64'(ready_pulses), 64'(p));
    chk("spur_err", err_flags, 3'b001);

    rsp_delay = 5;
    gups_req = 1'b1; gups_write = 1'b0; gups_addr = 64'h80;
    cyc = 0;
    while (log_q.size() == 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_rd_issued", log_q.size(), 1);
    @(negedge clk);
    gups_req = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_ready", 64'(ready_pulses), 64'(p));
    chk("abort_no_write", log_q.size(), 1);
    chk("abort_err", err_flags, 3'b001);
    log_q.delete();
    rsp_delay = 1;
    do_update("abort_recover", 64'h80, 64'h80, 64'h1236, 64'h1237, 3'b001, 0);

    // Random updates against a plain array model of memory.
    for (int i = 0; i < 16; i++) begin
      a = 64'h1000 + 64'(i) * 8;
      e = {$urandom, $urandom};
      mem_arr[a] = e;
      ref_mem[a] = e;
    end
    rnd_rdy = 1;
    exp_err = 3'b001;
    for (int i = 0; i < 40; i++) begin
      a = 64'h1000 + 64'($urandom_range(0, 15)) * 8;
      rsp_delay = $urandom_range(0, 4);
      e = ref_mem[a];
      do_update("rnd", a, a, e, e + 64'd1, exp_err, 0);
      ref_mem[a] = e + 64'd1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rnd_rdy = 0;

`ifdef GUPS_BRIDGE_TIMEOUT_EN
    do_reset();
    mute = 1; expect_to = 1;
    gups_req = 1'b1; gups_write = 1'b0; gups_addr = 64'h80;
    wait_ready("to_rd_rdy", 40, cyc);
    chk("to_rd_latency", 64'(cyc), 64'd11);
    chk("to_rd_data", gups_data_in, 0);
    chk("to_rd_err", err_flags, 3'b100);
    gups_write = 1'b1; gups_dout = 64'h1;
    wait_ready("to_wr_rdy", 40, cyc);
    chk("to_wr_count", update_count, 0);
    chk("to_wr_err", err_flags, 3'b100);
    gups_req = 1'b0; gups_write = 1'b0; mute = 0;
    @(negedge clk);
    inject_rsp = 1;
    repeat (3) @(negedge clk);
    chk("to_late_rsp", err_flags, 3'b101);
    expect_to = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
